// File: rtl/inc_share_arbiter_pkg.sv
// Shared definitions for the round-robin shared incrementer: FSM encodings and default sizes.
package inc_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 20;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/inc_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module inc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDW-1:0]     pick_idx,
  output logic               any_req
);

  int idx;

  // Scan from the farthest offset down so the closest request to ptr is the last write.
  always_comb begin
    pick_idx = '0;
    idx      = 0;
    any_req  = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) pick_idx = IDW'(idx);
    end
    pick = '0;
    if (any_req) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/inc_share_arbiter.sv
// One ripple incrementer shared by NUM_REQ counter owners through a round-robin arbiter.
// Build option: define INC_SATURATE_EN to clamp an all-ones operand instead of wrapping.
module inc_share_arbiter
  import inc_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] operand,
  output logic [NUM_REQ-1:0]       grant,
  output logic [WIDTH-1:0]         result,
  output logic                     cout,
  output logic [IDW-1:0]           result_id,
  output logic                     result_valid,
  input  logic                     result_ready,
  output state_t                   state,
  output logic [IDW-1:0]           rr_ptr
);

  // Handshake: result/cout/result_id are held while result_valid is high and
  // transfer on the rising edge where result_valid && result_ready.

  state_t               next_state;
  logic [NUM_REQ-1:0]   pick;
  logic [IDW-1:0]       pick_idx;
  logic                 any_req;
  logic [NUM_REQ-1:0]   win_oh;
  logic [IDW-1:0]       win_idx;
  logic                 sample_req;
  logic [WIDTH-1:0]     op_sel;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH:0]       carry;
  logic [WIDTH-1:0]     inc_res;

  inc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = CAPT;
      CAPT:    next_state = RESP;
      RESP:    if (result_ready) next_state = any_req ? CAPT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Requests only count when the arbiter is free to start a new capture.
  always_comb begin
    sample_req   = (state == IDLE) || (state == RESP && result_ready);
    grant        = (state == CAPT) ? win_oh : '0;
    result_valid = (state == RESP);
    op_sel       = operand[int'(win_idx)*WIDTH +: WIDTH];
  end

  assign carry[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_half_add
    assign sum[i]     = op_sel[i] ^ carry[i];
    assign carry[i+1] = op_sel[i] & carry[i];
  end

`ifdef INC_SATURATE_EN
  assign inc_res = carry[WIDTH] ? {WIDTH{1'b1}} : sum;
`else
  assign inc_res = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_oh    <= '0;
      win_idx   <= '0;
      result    <= '0;
      cout      <= 1'b0;
      result_id <= '0;
    end else begin
      state <= next_state;
      if (sample_req && any_req) begin
        win_oh  <= pick;
        win_idx <= pick_idx;
      end
      if (state == CAPT) begin
        result    <= inc_res;
        cout      <= carry[WIDTH];
        result_id <= win_idx;
        rr_ptr    <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/inc_share_arbiter.md
Name: inc_share_arbiter

Overview:
Shares a single ripple-carry incrementer among NUM_REQ requesters, such as the PC, stack pointer and address-walk counters.
- Requests are arbitrated round-robin; the winner's operand is captured, incremented, and the result returned with a valid/ready handshake.
- Sits between the control unit's counter owners and the one incrementer datapath, so none of them instantiates its own adder.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 20, operand/result width in bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request; held high until granted
operand  input  NUM_REQ*WIDTH  flat operands; requester i at bits [i*WIDTH +: WIDTH]
grant  output  NUM_REQ  one-hot, single-cycle pulse; operand sampled this cycle
result  output  WIDTH  operand + 1 (or saturated, see feature)
cout  output  1  carry out of MSB (operand was all-ones)
result_id  output  clog2(NUM_REQ), min 1  index of requester owning result
result_valid  output  1  result/cout/result_id valid
result_ready  input  1  consumer accepts result when valid && ready

Behaviour:
- Reset values (rst high at clock edge): grant=0, result=0, cout=0, result_id=0, result_valid=0, rr pointer=0, state=IDLE. This applies regardless of state, including mid-transaction; the in-flight result is dropped.
- States:
  - IDLE: if any req, go to CAPT; else stay.
  - CAPT: grant pulses for winner; operand latched into op_reg; winner index latched. Next state is RESP.
  - RESP: result_valid=1; outputs stable until handshake.
    - On result_valid && result_ready: if any req, go to CAPT (back-to-back); else IDLE.
- Incrementer computes combinationally from op_reg. result/cout register on CAPT->RESP.
- Latency: req seen in IDLE -> grant next cycle -> result_valid the cycle after. Peak throughput is 1 result per 2 cycles.
- Round-robin:
  - Search starts at index ptr and wraps modulo NUM_REQ; first asserted req wins.
  - After a grant to i, ptr = (i+1) mod NUM_REQ. ptr does not move without a grant.
- Requesters:
  - req sampled only in IDLE, or in RESP on the handshake cycle. Deasserting req before grant is legal (request withdrawn).
  - req held high after grant is treated as a new request.
- Operand may change freely except in the CAPT cycle of its own grant.
- Arithmetic: result = operand + 1 mod 2^WIDTH; cout=1 iff operand == all-ones.
- result_ready while result_valid=0 is ignored.

Optional Feature:
Macro INC_SATURATE_EN.
- Defined: all-ones operand yields result = all-ones, cout=1 (overflow flag); all other operands behave normally.
- Undefined: all-ones wraps to 0 with cout=1.
- All other behaviour and timing are identical in both builds.

Decomposition:
- Shared include holds: state encodings (IDLE=2'd0, CAPT=2'd1, RESP=2'd2), default WIDTH=20, NUM_REQ=4.
- One sub-module, inc_rr_pick: combinational round-robin picker. Inputs req and ptr; outputs one-hot pick, pick index and any_req.
- The incrementer is the existing half-adder chain, instantiated once; the saturate mux sits after it.

Test Plan:
- Single requester: req[2]=1, operand[2]=20'h0_00FF -> grant=4'b0100 one cycle later; next cycle result_valid=1, result=20'h0_0100, cout=0, result_id=2.
- Wrap: operand=20'hF_FFFF -> result=20'h0_0000, cout=1. With INC_SATURATE_EN: result=20'hF_FFFF, cout=1.
- Fairness: req=4'b1111 held, result_ready=1 -> grants cycle 0,1,2,3,0 in order; one grant every 2 cycles, no gaps.
- Backpressure: result_ready=0 for 5 cycles in RESP -> result, result_id and result_valid stable, no grant issued; ready=1 -> next grant the following cycle.
- Reset mid-op: rst=1 during RESP -> next cycle result_valid=0, grant=0, ptr=0; with req=4'b1010 the first grant is 4'b0010.
- Withdrawal: req[1] pulses for one cycle while in RESP with ready=0 -> no grant to 1, ptr unchanged.
